// File: rtl/uart_lite_pkg.sv
// Register map, status bit positions and engine states for the UART-lite echo engine.
package uart_lite_pkg;

  localparam logic [31:0] RX_OFS   = 32'h0000_0000;
  localparam logic [31:0] TX_OFS   = 32'h0000_0004;
  localparam logic [31:0] STAT_OFS = 32'h0000_0008;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT,
    S_DECIDE,
    S_RX,
    S_TX,
    S_GAP
  } echo_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with a read-first head; push and pop may coincide when not empty.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot a simultaneous push needs, so full+push+pop is legal.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_uart_echo_engine.sv
// AXI4-lite master polling a UART-lite slave: drains RX into a FIFO and writes
// each byte plus INCR back to TX whenever the transmitter has room.
module axi_uart_echo_engine
  import uart_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [7:0]  INCR       = 8'd1,
  parameter int          FIFO_DEPTH = 16,
  parameter int          POLL_GAP   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [31:0]                   awaddr,
  output logic [2:0]                    awprot,
  output logic                          wvalid,
  input  logic                          wready,
  output logic [31:0]                   wdata,
  output logic [3:0]                    wstrb,
  input  logic                          bvalid,
  output logic                          bready,
  input  logic [1:0]                    bresp,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [31:0]                   araddr,
  output logic [2:0]                    arprot,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [31:0]                   rdata,
  input  logic [1:0]                    rresp,
  output logic [15:0]                   rx_cnt,
  output logic [15:0]                   tx_cnt,
  output logic                          err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  echo_state_e state_q, state_d;
  logic        ar_done_q, aw_done_q, w_done_q;
  logic        stat_rx_q, stat_txf_q;
  logic [15:0] gap_q, rx_cnt_q, tx_cnt_q;
  logic        err_q;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic        r_hs, b_hs, rd_state;
  logic        unused_rdata;

  assign rd_state     = (state_q == S_STAT) || (state_q == S_RX);
  assign r_hs         = rvalid && rready;
  assign b_hs         = bvalid && bready;
  assign fifo_push    = (state_q == S_RX) && r_hs && (rresp == AXI_RESP_OKAY);
  assign fifo_pop     = (state_q == S_TX) && b_hs;
  assign unused_rdata = ^rdata[31:8];

  assign rx_cnt = rx_cnt_q;
  assign tx_cnt = tx_cnt_q;
  assign err    = err_q;

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .data_i  (rdata[7:0]),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_STAT;
      S_STAT:   if (r_hs) state_d = S_DECIDE;
      // RX wins; a full FIFO falls through to TX so it can never overrun.
      S_DECIDE: begin
        if (stat_rx_q && !fifo_full)        state_d = S_RX;
        else if (!fifo_empty && !stat_txf_q) state_d = S_TX;
        else if (POLL_GAP == 0)              state_d = S_IDLE;
        else                                 state_d = S_GAP;
      end
      S_RX:     if (r_hs) state_d = S_IDLE;
      S_TX:     if (b_hs) state_d = S_IDLE;
      S_GAP:    if (gap_q == 16'(POLL_GAP - 1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    araddr  = '0;
    arprot  = 3'b000;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    awaddr  = '0;
    awprot  = 3'b000;
    wdata   = '0;
    wstrb   = 4'b0000;
    if (rd_state) begin
      arvalid = !ar_done_q;
      rready  = 1'b1;
      araddr  = BASE_ADDR + ((state_q == S_STAT) ? STAT_OFS : RX_OFS);
    end
    if (state_q == S_TX) begin
      awvalid = !aw_done_q;
      wvalid  = !w_done_q;
      bready  = aw_done_q && w_done_q;
      awaddr  = BASE_ADDR + TX_OFS;
      wdata   = {24'd0, fifo_head + INCR};
      wstrb   = 4'b0001;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_done_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      stat_rx_q  <= 1'b0;
      stat_txf_q <= 1'b0;
      gap_q      <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (arvalid && arready) ar_done_q <= 1'b1;
      if (r_hs)               ar_done_q <= 1'b0;
      if (awvalid && awready) aw_done_q <= 1'b1;
      if (wvalid && wready)   w_done_q  <= 1'b1;
      if (b_hs) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if ((state_q == S_STAT) && r_hs) begin
        stat_rx_q  <= rdata[STAT_RX_VALID];
        stat_txf_q <= rdata[STAT_TX_FULL];
      end
      gap_q <= (state_q == S_GAP) ? gap_q + 16'd1 : 16'd0;
      if (fifo_push) rx_cnt_q <= rx_cnt_q + 16'd1;
      if (fifo_pop && (bresp == AXI_RESP_OKAY)) tx_cnt_q <= tx_cnt_q + 16'd1;
      if ((r_hs && (rresp != AXI_RESP_OKAY)) || (b_hs && (bresp != AXI_RESP_OKAY))) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_uart_echo_engine.sv
// Directed bench: a behavioural UART-lite slave feeds RX bytes and logs TX writes.
module tb_axi_uart_echo_engine;
  import uart_lite_pkg::*;

  localparam logic [31:0] BASE  = 32'h4000_1000;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [15:0] rx_cnt, tx_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  axi_uart_echo_engine #(
    .BASE_ADDR(BASE), .INCR(8'd1), .FIFO_DEPTH(DEPTH), .POLL_GAP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rx_cnt(rx_cnt), .tx_cnt(tx_cnt), .err(err), .fifo_level(fifo_level)
  );

  // Slave model state and configuration
  logic [7:0]  rx_q[$];
  logic        tx_full = 1'b0;
  int          aw_delay = 0;
  int          w_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  int          aw_wait, w_wait;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  logic [3:0]  w_strb_l;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_strb[$];
  int          aw_hs = 0;
  int          w_hs = 0;
  int          viol = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
    end else begin
      if (arvalid && arready) begin
        arready <= 1'b0;
        rvalid  <= 1'b1;
        rresp   <= 2'b00;
        if (araddr == BASE + STAT_OFS) begin
          rdata <= {28'd0, tx_full, 2'b00, (rx_q.size() != 0)};
        end else if (araddr == BASE + RX_OFS && rx_q.size() != 0) begin
          rdata <= {24'd0, rx_q[0]};
          $display("RX  read  byte=0x%02h", rx_q[0]);
          void'(rx_q.pop_front());
        end else begin
          rdata <= '0;
        end
      end else if (arvalid && !rvalid) begin
        arready <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;

      if (awvalid && awready) begin
        awready <= 1'b0; aw_got <= 1'b1; aw_addr_l <= awaddr; aw_hs <= aw_hs + 1; aw_wait <= 0;
      end else if (awvalid && !aw_got) begin
        if (aw_wait >= aw_delay) awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (wvalid && wready) begin
        wready <= 1'b0; w_got <= 1'b1; w_data_l <= wdata; w_strb_l <= wstrb; w_hs <= w_hs + 1; w_wait <= 0;
      end else if (wvalid && !w_got) begin
        if (w_wait >= w_delay) wready <= 1'b1;
        else w_wait <= w_wait + 1;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid <= 1'b1; bresp <= bresp_cfg;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        log_addr.push_back(aw_addr_l);
        log_data.push_back(w_data_l);
        log_strb.push_back(w_strb_l);
        $display("TX  write addr=0x%08h data=0x%08h strb=0x%h resp=%0d", aw_addr_l, w_data_l, w_strb_l, bresp);
      end
    end
  end

  // bready must never precede completion of both address and data phases
  always @(negedge clk) begin
    if (rst_n && ((bready && !(aw_got && w_got)) || (arvalid && !rready))) viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (log_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, log_data.size(), n);
  endtask

  task automatic expect_tx(input int idx, input logic [7:0] b, input string tag);
    check({tag, "_data"}, log_data[idx], {24'd0, b});
    check({tag, "_addr"}, log_addr[idx], BASE + TX_OFS);
    check({tag, "_strb"}, {28'd0, log_strb[idx]}, 32'h1);
  endtask

  logic [7:0] in3[3]  = '{8'hFF, 8'h00, 8'h7F};
  logic [7:0] out3[3] = '{8'h00, 8'h01, 8'h80};

  initial begin
    int n0, k, exp_rx, exp_tx;
    logic found;

    repeat (3) @(negedge clk);
    check("rst_arvalid", {31'd0, arvalid}, 0);
    check("rst_awvalid", {31'd0, awvalid}, 0);
    check("rst_wvalid", {31'd0, wvalid}, 0);
    check("rst_bready", {31'd0, bready}, 0);
    check("rst_rready", {31'd0, rready}, 0);
    check("rst_araddr", araddr, 0);
    check("rst_cnts", {rx_cnt, tx_cnt}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // single byte echo with +1
    rx_q.push_back(8'h41);
    wait_tx(1, 300, "t1_wait");
    expect_tx(0, 8'h42, "t1");
    check("t1_rx_cnt", rx_cnt, 1);
    check("t1_tx_cnt", tx_cnt, 1);
    exp_rx = 1; exp_tx = 1;

    // wrap-around bytes
    for (int i = 0; i < 3; i++) rx_q.push_back(in3[i]);
    wait_tx(4, 600, "t3_wait");
    for (int i = 0; i < 3; i++) expect_tx(1 + i, out3[i], $sformatf("t3_%0d", i));
    exp_rx += 3; exp_tx += 3;

    // tx_full backpressure fills the FIFO without over-reading RX
    tx_full = 1'b1;
    n0 = log_data.size();
    for (int i = 0; i < 20; i++) rx_q.push_back(8'h20 + 8'(i));
    k = 0;
    while (fifo_level != 16 && k < 2000) begin @(negedge clk); k++; end
    repeat (100) @(negedge clk);
    check("t4_level", fifo_level, 16);
    check("t4_rx_left", rx_q.size(), 4);
    check("t4_rx_cnt", rx_cnt, 16'(exp_rx + 16));
    check("t4_no_tx", log_data.size(), n0);
    tx_full = 1'b0;
    wait_tx(n0 + 20, 4000, "t4_wait");
    for (int i = 0; i < 20; i++) expect_tx(n0 + i, 8'h21 + 8'(i), $sformatf("t4_%0d", i));
    exp_rx += 20; exp_tx += 20;
    check("t4_rx_cnt_end", rx_cnt, 16'(exp_rx));
    check("t4_level_end", fifo_level, 0);

    // delayed awready, then delayed wready
    for (int d = 0; d < 2; d++) begin
      aw_delay = (d == 0) ? 3 : 0;
      w_delay  = (d == 0) ? 0 : 3;
      n0 = log_data.size();
      rx_q.push_back(8'h30 + 8'(d));
      wait_tx(n0 + 1, 300, $sformatf("t5_wait%0d", d));
      repeat (20) @(negedge clk);
      expect_tx(n0, 8'h31 + 8'(d), $sformatf("t5_%0d", d));
      check($sformatf("t5_aw_hs%0d", d), aw_hs, log_data.size());
      check($sformatf("t5_w_hs%0d", d), w_hs, log_data.size());
      exp_rx++; exp_tx++;
    end
    aw_delay = 0; w_delay = 0;
    check("t5_protocol", viol, 0);
    check("t5_tx_cnt", tx_cnt, 16'(exp_tx));

    // SLVERR on the TX write
    bresp_cfg = 2'b10;
    n0 = log_data.size();
    rx_q.push_back(8'h50);
    wait_tx(n0 + 1, 300, "t6_wait");
    bresp_cfg = 2'b00;
    exp_rx++;
    check("t6_err", {31'd0, err}, 1);
    check("t6_tx_cnt", tx_cnt, 16'(exp_tx));
    check("t6_level", fifo_level, 0);
    rx_q.push_back(8'h51);
    wait_tx(n0 + 2, 300, "t6_wait2");
    exp_rx++; exp_tx++;
    check("t6_err_sticky", {31'd0, err}, 1);
    check("t6_tx_cnt2", tx_cnt, 16'(exp_tx));
    check("t6_rx_cnt", rx_cnt, 16'(exp_rx));

    // enable dropped during an RX read
    n0 = log_data.size();
    rx_q.push_back(8'h55);
    found = 1'b0;
    k = 0;
    while (!found && k < 300) begin
      @(negedge clk);
      k++;
      if (arvalid && araddr == BASE + RX_OFS) found = 1'b1;
    end
    check("t7_rx_seen", {31'd0, found}, 1);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    exp_rx++;
    check("t7_rx_cnt", rx_cnt, 16'(exp_rx));
    check("t7_level", fifo_level, 1);
    check("t7_parked", log_data.size(), n0);
    check("t7_idle_bus", {30'd0, arvalid, awvalid}, 0);
    enable = 1'b1;
    wait_tx(n0 + 1, 300, "t7_wait");
    expect_tx(n0, 8'h56, "t7");

    // reset in the middle of a write
    aw_delay = 10;
    rx_q.push_back(8'h60);
    found = 1'b0;
    k = 0;
    while (!found && k < 300) begin
      @(negedge clk);
      k++;
      if (awvalid) found = 1'b1;
    end
    check("t8_write_seen", {31'd0, found}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t8_awvalid", {31'd0, awvalid}, 0);
    check("t8_wvalid", {31'd0, wvalid}, 0);
    check("t8_bready", {31'd0, bready}, 0);
    check("t8_awaddr", awaddr, 0);
    check("t8_wdata", wdata, 0);
    check("t8_cnts", {rx_cnt, tx_cnt}, 0);
    check("t8_err", {31'd0, err}, 0);
    check("t8_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
